// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving one shared 2:1 data path.
// The mux select is locked to one requester for a whole burst. A burst ends
// on the requester's last flag or when MAX_BURST beats have been transferred.
// Priority then rotates, and one IDLE cycle always separates two bursts.
//
// state | meaning
// IDLE  | no owner; all outputs low; picks the next owner from the valids
// BUSY  | path locked to sel_q; beats move on out_valid & out_ready
module mux2_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_valid,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_last,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_last,
    output logic          in1_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic [1:0]    grant,
    output logic          busy
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          xfer;

    // State and arbitration registers; reset leaves priority pointing at req0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state decode plus the output mux, which is driven only while BUSY.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        in0_ready  = 1'b0;
        in1_ready  = 1'b0;
        grant      = 2'b00;
        busy       = 1'b0;
        xfer       = 1'b0;

        unique case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (in0_valid && in1_valid) begin
                    sel_d   = ~last_gnt_q;
                    state_d = BUSY;
                end else if (in0_valid) begin
                    sel_d   = 1'b0;
                    state_d = BUSY;
                end else if (in1_valid) begin
                    sel_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy      = 1'b1;
                grant     = sel_q ? 2'b10 : 2'b01;
                out_data  = sel_q ? in1_data : in0_data;
                out_valid = sel_q ? in1_valid : in0_valid;
                out_last  = (sel_q ? in1_last : in0_last) | (beat_cnt_q == CNT_LAST);
                in0_ready = ~sel_q & out_ready;
                in1_ready = sel_q & out_ready;
                xfer      = out_valid & out_ready;
                // A stalled or empty cycle leaves the counter and owner alone,
                // so a requester that goes quiet keeps its grant.
                if (xfer) begin
                    if (out_last) begin
                        last_gnt_d = sel_q;
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
